// File: rtl/reg_bank_writer_if.sv
// Bus bundle for reg_bank_writer: write port, clear control, status and the A..G register outputs.
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready; the master keeps
// wr_sel/wr_data stable while wr_valid is high and the write has not yet been accepted.
interface reg_bank_writer_if #(
  parameter int DW    = 8,
  parameter int CNT_W = 8
);
  logic             wr_valid;
  logic [3:0]       wr_sel;
  logic [DW-1:0]    wr_data;
  logic             wr_ready;
  logic             clr_req;
  logic             clr_busy;
  logic             clr_done;
  logic             wr_ack;
  logic [CNT_W-1:0] wr_count;
  logic [DW-1:0]    A, B, C, D, E, F, G;
  logic             sel_err;

  modport master (
    output wr_valid, wr_sel, wr_data, clr_req,
    input  wr_ready, clr_busy, clr_done, wr_ack, wr_count,
    input  A, B, C, D, E, F, G, sel_err
  );

  modport slave (
    input  wr_valid, wr_sel, wr_data, clr_req,
    output wr_ready, clr_busy, clr_done, wr_ack, wr_count,
    output A, B, C, D, E, F, G, sel_err
  );
endinterface

// File: rtl/reg_bank_writer.sv
// 7 x DW register bank (A..G) written through the operand-mux select encoding, with a
// sequential clear sweep and an accepted-write counter. Optional macro: REG_SEL_STRICT_EN.
module reg_bank_writer #(
  parameter int DW    = 8,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_bank_writer_if.slave    bus,
  output logic                dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       clr_idx_q, clr_idx_d;
  logic             wr_ack_q, wr_ack_d;
  logic             clr_done_q, clr_done_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic [DW-1:0]    regs_q [7];

  logic [2:0] wr_idx;
  logic       sel_legal;
  logic       wr_ready;
  logic       write_en;
  logic       clear_en;

  // Same encoding as the read mux: A..F on 0100..1001, everything else lands on G.
  always_comb begin
    wr_idx    = 3'd6;
    sel_legal = 1'b1;
    case (bus.wr_sel)
      4'b0100: wr_idx = 3'd0;
      4'b0101: wr_idx = 3'd1;
      4'b0110: wr_idx = 3'd2;
      4'b0111: wr_idx = 3'd3;
      4'b1000: wr_idx = 3'd4;
      4'b1001: wr_idx = 3'd5;
      4'b1010: wr_idx = 3'd6;
      default: begin
        wr_idx = 3'd6;
`ifdef REG_SEL_STRICT_EN
        sel_legal = 1'b0;
`endif
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    wr_ack_d   = 1'b0;
    clr_done_d = 1'b0;
    wr_count_d = wr_count_q;
    wr_ready   = 1'b0;
    write_en   = 1'b0;
    clear_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_ready = !bus.clr_req;
        if (bus.clr_req) begin
          state_d   = S_CLEAR;
          clr_idx_d = 3'd0;
        end else if (bus.wr_valid) begin
          wr_ack_d = 1'b1;
          write_en = sel_legal;
          if (sel_legal) wr_count_d = wr_count_q + CNT_W'(1);
        end
      end
      S_CLEAR: begin
        clear_en = 1'b1;
        if (clr_idx_q == 3'd6) begin
          state_d    = S_IDLE;
          clr_idx_d  = 3'd0;
          clr_done_d = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      clr_idx_q  <= 3'd0;
      wr_ack_q   <= 1'b0;
      clr_done_q <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      wr_ack_q   <= wr_ack_d;
      clr_done_q <= clr_done_d;
      wr_count_q <= wr_count_d;
    end
  end

  // The sweep and a write never coincide: writes are only taken in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (clear_en && clr_idx_q == 3'(i)) regs_q[i] <= '0;
        else if (write_en && wr_idx == 3'(i)) regs_q[i] <= bus.wr_data;
      end
    end
  end

`ifdef REG_SEL_STRICT_EN
  logic sel_err_q;
  logic sel_err_set;
  assign sel_err_set = (state_q == S_IDLE) && !bus.clr_req && bus.wr_valid && !sel_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           sel_err_q <= 1'b0;
    else if (sel_err_set) sel_err_q <= 1'b1;
  end
  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif

  assign bus.wr_ready  = wr_ready;
  assign bus.clr_busy  = (state_q == S_CLEAR);
  assign bus.clr_done  = clr_done_q;
  assign bus.wr_ack    = wr_ack_q;
  assign bus.wr_count  = wr_count_q;
  assign bus.A         = regs_q[0];
  assign bus.B         = regs_q[1];
  assign bus.C         = regs_q[2];
  assign bus.D         = regs_q[3];
  assign bus.E         = regs_q[4];
  assign bus.F         = regs_q[5];
  assign bus.G         = regs_q[6];
  assign dbg_state_o   = (state_q == S_CLEAR);

endmodule

// File: tb/tb_reg_bank_writer.sv
// Bench for reg_bank_writer: directed and random steps checked every cycle against a
// register-array model of the bank, its clear sweep and the write counter.
module tb_reg_bank_writer;

  logic clk;
  logic rst_n;
  logic dbg_state;

  reg_bank_writer_if #(.DW(8), .CNT_W(8)) bus ();

  reg_bank_writer #(.DW(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] exp_regs [7];
  logic [7:0] exp_count;
  logic       exp_ack;
  logic       exp_done;
  logic       exp_err;
  int         clr_left;

  function automatic int decode(input logic [3:0] s);
    if (s >= 4'd4 && s <= 4'd9) return int'(s) - 4;
`ifdef REG_SEL_STRICT_EN
    if (s == 4'd10) return 6;
    return -1;
`else
    return 6;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) exp_regs[i] = 8'h00;
    exp_count = 8'h00;
    exp_ack   = 1'b0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    clr_left  = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] s, input logic [7:0] d, input logic c);
    int idx;
    exp_ack  = 1'b0;
    exp_done = 1'b0;
    if (clr_left == 0) begin
      if (c) begin
        clr_left = 7;
      end else if (v) begin
        exp_ack = 1'b1;
        idx = decode(s);
        if (idx >= 0) begin
          exp_regs[idx] = d;
          exp_count     = exp_count + 8'd1;
        end else begin
          exp_err = 1'b1;
        end
      end
    end else begin
      exp_regs[7 - clr_left] = 8'h00;
      clr_left--;
      if (clr_left == 0) exp_done = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".regs"}, {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G},
          {exp_regs[0], exp_regs[1], exp_regs[2], exp_regs[3], exp_regs[4], exp_regs[5], exp_regs[6]});
    check({tag, ".count"}, bus.wr_count, exp_count);
    check({tag, ".ack"},   bus.wr_ack,   exp_ack);
    check({tag, ".done"},  bus.clr_done, exp_done);
    check({tag, ".busy"},  bus.clr_busy, clr_left != 0);
    check({tag, ".state"}, dbg_state,    clr_left != 0);
    check({tag, ".err"},   bus.sel_err,  exp_err);
  endtask

  // One clock: drive inputs, check ready before the edge, check all state after it.
  task automatic cycle(input logic v, input logic [3:0] s, input logic [7:0] d, input logic c,
                       input string tag);
    bus.wr_valid = v;
    bus.wr_sel   = s;
    bus.wr_data  = d;
    bus.clr_req  = c;
    #1;
    check({tag, ".ready"}, bus.wr_ready, (clr_left == 0) && !c);
    model_step(v, s, d, c);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.wr_valid = 1'b0;
    bus.clr_req  = 1'b0;
    #1;
    check({tag, ".ready"}, bus.wr_ready, 1'b1);
  endtask

  task automatic fill_regs(input string tag);
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 4'(i + 4), 8'($urandom_range(1, 255)), 1'b0, tag);
  endtask

  initial begin
    logic [55:0] t2_vals;
    rst_n        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_sel   = 4'd0;
    bus.wr_data  = 8'h00;
    bus.clr_req  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: some traffic, then reset mid-run
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 4'($urandom_range(4, 10)), 8'($urandom), 1'b0, "t1_fill");
    async_reset("t1_rst");

    // T2: decode of every legal code, back-to-back
    t2_vals = 56'h11223344556677;
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 4'(i + 4), t2_vals[55 - 8*i -: 8], 1'b0, "t2_decode");
    cycle(1'b0, 4'd0, 8'h00, 1'b0, "t2_idle");
    check("t2_regs_const", {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G}, t2_vals);
    check("t2_count_const", bus.wr_count, 8'd7);

    // T3: default select path
    cycle(1'b1, 4'b0000, 8'hAB, 1'b0, "t3_default");
    cycle(1'b0, 4'd0, 8'h00, 1'b0, "t3_idle");

    // Same code twice in a row: last write wins
    cycle(1'b1, 4'b0101, 8'hC3, 1'b0, "ovr_1");
    cycle(1'b1, 4'b0101, 8'h3C, 1'b0, "ovr_2");

    // T4: full clear sweep
    fill_regs("t4_fill");
    cycle(1'b0, 4'd0, 8'h00, 1'b1, "t4_req");
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'd0, 8'h00, 1'b0, "t4_sweep");

    // T5: collision, then write held through the sweep
    fill_regs("t5_fill");
    cycle(1'b1, 4'b0100, 8'h5A, 1'b1, "t5_collide");
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'b0100, 8'h5A, 1'b0, "t5_hold");
    cycle(1'b0, 4'd0, 8'h00, 1'b0, "t5_after");
    check("t5_a_const", bus.A, 8'h5A);

    // Random mix of writes, clears and idle cycles
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 8'($urandom),
            1'($urandom_range(0, 15) == 0), "rand");
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'd0, 8'h00, 1'b0, "rand_drain");

    // T6: counter wrap from zero
    async_reset("t6_rst");
    for (int i = 0; i < 256; i++)
      cycle(1'b1, 4'($urandom_range(4, 10)), 8'($urandom), 1'b0, "t6_wrap");
    check("t6_count_wrap", bus.wr_count, 8'd0);

    // Reset landing on clear index 3
    fill_regs("t6_fill");
    cycle(1'b0, 4'd0, 8'h00, 1'b1, "t6_req");
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 8'h00, 1'b0, "t6_sweep");
    check("t6_d_kept", bus.D != 8'h00, 1'b1);
    check("t6_g_kept", bus.G != 8'h00, 1'b1);
    async_reset("t6_rst_mid_clear");
    cycle(1'b1, 4'b0110, 8'h99, 1'b0, "t6_post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
